// File: rtl/spi_burst_ctrl_pkg.sv
// Shared types and constants for the SPI burst controller.
package spi_burst_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_WAIT,
    ST_GAP,
    ST_HOLD
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_fifo.sv
// Synchronous FIFO with a registered show-ahead head, registered full/empty flags
// and an occupancy counter. Simultaneous push and pop are honoured when full or empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Next head is read from the post-write memory image so a push into an empty FIFO shows at once.
  always_comb begin
    push_ok  = push && (!full_q || pop);
    pop_ok   = pop && (!empty_q || push);
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    rdata_d  = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = rdata_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of the SPI byte engine: splits a multi-byte request into
// byte_start/byte_done handshakes, owns chip-select setup/hold and buffers TX/RX bytes.
module spi_burst_ctrl
  import spi_burst_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned GAP      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_wr,
  input  logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_full,
  input  logic                   req_valid,
  input  logic [$clog2(DEPTH):0] req_len,
  output logic                   req_ready,
  input  logic                   rx_rd,
  output logic [BYTE_W-1:0]      rx_data,
  output logic                   rx_empty,
  output logic                   spi_cs_n,
  output logic                   byte_start,
  output logic [BYTE_W-1:0]      byte_tx,
  input  logic                   byte_done,
  input  logic [BYTE_W-1:0]      byte_rx,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   err
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned TW       = $clog2(max3(CS_SETUP, CS_HOLD, GAP) + 1);
  localparam int unsigned SETUP_LD = (CS_SETUP > 0) ? CS_SETUP - 1 : 0;
  localparam int unsigned HOLD_LD  = (CS_HOLD > 0) ? CS_HOLD - 1 : 0;
  localparam int unsigned GAP_LD   = (GAP > 0) ? GAP - 1 : 0;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     remain_q, remain_d;
  logic              cs_n_q, cs_n_d;
  logic              byte_start_q, byte_start_d;
  logic [BYTE_W-1:0] byte_tx_q, byte_tx_d;
  logic              burst_done_q, burst_done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;

  logic              accept, len_bad;
  logic              tx_pop, tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic [CW-1:0]     tx_count;
  logic              rx_push, rx_full, rx_drop;
  logic [CW-1:0]     rx_count_unused;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (byte_rx),
    .pop   (rx_rd),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count_unused)
  );

  assign accept  = req_valid && req_ready_q;
  assign len_bad = (req_len == '0) || (req_len > tx_count);
  assign rx_push = (state_q == ST_WAIT) && byte_done;
  // A full RX FIFO still takes the byte when the host pops in the same cycle.
  assign rx_drop = rx_push && rx_full && !rx_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      remain_q     <= '0;
      cs_n_q       <= 1'b1;
      byte_start_q <= 1'b0;
      byte_tx_q    <= '0;
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      remain_q     <= remain_d;
      cs_n_q       <= cs_n_d;
      byte_start_q <= byte_start_d;
      byte_tx_q    <= byte_tx_d;
      burst_done_q <= burst_done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // One timer serves SETUP, GAP and HOLD; it is loaded with (cycles - 1) on entry.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !len_bad) begin
          state_d  = ST_SETUP;
          remain_d = req_len;
          timer_d  = TW'(SETUP_LD);
        end
      end
      ST_SETUP: begin
        if (timer_q == '0) state_d = ST_XFER;
        else               timer_d = timer_q - TW'(1);
      end
      ST_XFER: state_d = ST_WAIT;
      ST_WAIT: begin
        if (byte_done) begin
          remain_d = remain_q - CW'(1);
          if (remain_q == CW'(1)) begin
            state_d = ST_HOLD;
            timer_d = TW'(HOLD_LD);
          end else if (GAP == 0) begin
            state_d = ST_XFER;
          end else begin
            state_d = ST_GAP;
            timer_d = TW'(GAP_LD);
          end
        end
      end
      ST_GAP: begin
        if (timer_q == '0) state_d = ST_XFER;
        else               timer_d = timer_q - TW'(1);
      end
      ST_HOLD: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with the state.
  always_comb begin
    cs_n_d       = (state_d == ST_IDLE);
    byte_start_d = (state_d == ST_XFER);
    byte_tx_d    = byte_tx_q;
    tx_pop       = 1'b0;
    if (state_d == ST_XFER) begin
      byte_tx_d = tx_head;
      tx_pop    = !tx_empty;
    end
    burst_done_d = (state_q == ST_HOLD) && (state_d == ST_IDLE);
    err_d        = (accept && len_bad) || rx_drop;
    busy_d       = (state_d != ST_IDLE);
    req_ready_d  = (state_d == ST_IDLE);
  end

  assign spi_cs_n   = cs_n_q;
  assign byte_start = byte_start_q;
  assign byte_tx    = byte_tx_q;
  assign burst_done = burst_done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign req_ready  = req_ready_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: byte engine model (done N cycles after start, rx = ~tx),
// queue-based FIFO model and burst timing derived from the setup/gap/hold arithmetic.
module tb_spi_burst_ctrl;

  localparam int DEPTH    = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int GAP      = 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_wr = 1'b0;
  logic [7:0]    tx_data = '0;
  logic          tx_full;
  logic          req_valid = 1'b0;
  logic [CW-1:0] req_len = '0;
  logic          req_ready;
  logic          rx_rd = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          spi_cs_n, byte_start, busy, burst_done, err;
  logic [7:0]    byte_tx;
  logic          byte_done = 1'b0;
  logic [7:0]    byte_rx = '0;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.DEPTH(DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .spi_cs_n(spi_cs_n), .byte_start(byte_start), .byte_tx(byte_tx),
    .byte_done(byte_done), .byte_rx(byte_rx),
    .busy(busy), .burst_done(burst_done), .err(err)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  int         eng_n = 1;
  int         eng_cnt = 0;
  logic [7:0] eng_byte = '0;

  // Byte engine: byte_done exactly eng_n cycles after byte_start is seen.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      byte_done = 1'b0;
      if (rst) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt != 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            byte_done = 1'b1;
            byte_rx   = eng_byte;
          end
        end
        if (byte_start) begin
          eng_byte = ~byte_tx;
          eng_cnt  = eng_n;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_wr = 1'b1; tx_data = b;
    tick();
    tx_wr = 1'b0;
    if (tx_m.size() < DEPTH) tx_m.push_back(b);
    chk("tx_full", 32'(tx_full), 32'(tx_m.size() == DEPTH));
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) begin
      chk("rx_empty", 32'(rx_empty), 32'(rx_m.size() == 0));
      if (rx_m.size() > 0) chk("rx_data", 32'(rx_data), 32'(rx_m[0]));
      rx_rd = 1'b1;
      tick();
      rx_rd = 1'b0;
      if (rx_m.size() > 0) void'(rx_m.pop_front());
    end
    chk("rx_empty_end", 32'(rx_empty), 32'(rx_m.size() == 0));
  endtask

  // Issue one request and check every output cycle by cycle against the timing
  // rules: t counts cycles after the accept edge.
  task automatic run_req(input int len, input int n, output int obs_err, output int obs_starts);
    logic [7:0] exp_b[$];
    int         s[$];
    int         d[$];
    int         err_at[$];
    logic [7:0] b;
    bit         ok;
    int         e, idx;
    bit         exp_start, exp_err;
    ok = (len != 0) && (len <= tx_m.size());
    chk("req_ready_pre", 32'(req_ready), 32'd1);
    eng_n = n;
    req_valid = 1'b1; req_len = CW'(len);
    tick();
    req_valid = 1'b0;
    obs_err = int'(err);
    obs_starts = 0;
    if (!ok) begin
      for (int t = 1; t <= CS_SETUP + 4; t++) begin
        chk("rej_err", 32'(err), 32'(t == 1));
        chk("rej_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rej_start", 32'(byte_start), 32'd0);
        chk("rej_busy", 32'(busy), 32'd0);
        if (byte_start) obs_starts++;
        tick();
      end
    end else begin
      for (int k = 0; k < len; k++) begin
        b = tx_m.pop_front();
        exp_b.push_back(b);
        s.push_back(CS_SETUP + 1 + k * (n + GAP + 1));
        d.push_back(s[k] + n);
        if (rx_m.size() < DEPTH) rx_m.push_back(~b);
        else err_at.push_back(d[k] + 1);
      end
      e = d[len-1] + CS_HOLD + 1;
      for (int t = 1; t <= e + 1; t++) begin
        exp_start = 1'b0; exp_err = 1'b0; idx = -1;
        for (int k = 0; k < len; k++) begin
          if (t == s[k]) exp_start = 1'b1;
          if (t >= s[k] && t <= d[k]) idx = k;
        end
        foreach (err_at[j]) if (err_at[j] == t) exp_err = 1'b1;
        chk("cs_n", 32'(spi_cs_n), 32'(t >= e));
        chk("busy", 32'(busy), 32'(t < e));
        chk("req_ready", 32'(req_ready), 32'(t >= e));
        chk("byte_start", 32'(byte_start), 32'(exp_start));
        chk("burst_done", 32'(burst_done), 32'(t == e));
        chk("err", 32'(err), 32'(exp_err));
        if (idx >= 0) chk("byte_tx", 32'(byte_tx), 32'(exp_b[idx]));
        if (byte_start) obs_starts++;
        tick();
      end
    end
  endtask

  typedef struct {
    int npush;
    int len;
    int n;
    int exp_err;
    int exp_starts;
  } vec_t;

  initial begin
    vec_t vt[7];
    int   oe, os, p, len, r;

    vt[0] = '{npush: 1, len: 2, n: 2, exp_err: 1, exp_starts: 0};
    vt[1] = '{npush: 0, len: 0, n: 2, exp_err: 1, exp_starts: 0};
    vt[2] = '{npush: 0, len: 1, n: 1, exp_err: 0, exp_starts: 1};
    vt[3] = '{npush: 8, len: 8, n: 1, exp_err: 0, exp_starts: 8};
    vt[4] = '{npush: 3, len: 4, n: 3, exp_err: 1, exp_starts: 0};
    vt[5] = '{npush: 0, len: 3, n: 4, exp_err: 0, exp_starts: 3};
    vt[6] = '{npush: 9, len: 8, n: 2, exp_err: 0, exp_starts: 8};

    // Reset values
    repeat (3) tick();
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_start", 32'(byte_start), 32'd0);
    chk("rst_byte_tx", 32'(byte_tx), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Two-byte burst A5, 3C
    push_byte(8'hA5);
    push_byte(8'h3C);
    run_req(2, 3, oe, os);
    chk("t1_starts", 32'(os), 32'd2);
    chk("t1_rx0", 32'(rx_data), 32'h5A);
    drain(2);

    // Table vectors
    for (int v = 0; v < 7; v++) begin
      drain(rx_m.size());
      for (int i = 0; i < vt[v].npush; i++) push_byte(8'($urandom));
      run_req(vt[v].len, vt[v].n, oe, os);
      chk("vec_err", 32'(oe), 32'(vt[v].exp_err));
      chk("vec_starts", 32'(os), 32'(vt[v].exp_starts));
    end

    // RX overflow: 7 queued, burst of 2 stores the 8th and drops the 9th
    if (tx_m.size() > 0) run_req(tx_m.size(), 1, oe, os);
    drain(rx_m.size());
    for (int i = 0; i < 7; i++) push_byte(8'($urandom));
    run_req(7, 1, oe, os);
    push_byte(8'h11);
    push_byte(8'h22);
    run_req(2, 2, oe, os);
    chk("ovf_rx_empty", 32'(rx_empty), 32'd0);
    chk("ovf_rx_count", 32'(rx_m.size()), 32'(DEPTH));
    drain(DEPTH);

    // Randomised bursts against the queue model
    for (int it = 0; it < 25; it++) begin
      drain(int'($urandom_range(0, rx_m.size())));
      p = int'($urandom_range(0, DEPTH - tx_m.size() + 1));
      for (int i = 0; i < p; i++) push_byte(8'($urandom));
      r = int'($urandom_range(0, 9));
      if (r == 0)      len = 0;
      else if (r == 1) len = tx_m.size() + 1;
      else             len = int'($urandom_range(1, (tx_m.size() > 0) ? tx_m.size() : 1));
      run_req(len, int'($urandom_range(1, 4)), oe, os);
    end

    // Asynchronous reset while waiting on byte 2
    drain(rx_m.size());
    if (tx_m.size() > 0) run_req(tx_m.size(), 1, oe, os);
    drain(rx_m.size());
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    eng_n = 4;
    req_valid = 1'b1; req_len = CW'(3);
    tick();
    req_valid = 1'b0;
    repeat (13) tick();
    chk("mid_cs_n", 32'(spi_cs_n), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_rx_empty", 32'(rx_empty), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rx_empty", 32'(rx_empty), 32'd1);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tx_m.delete();
    rx_m.delete();
    tick();
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    run_req(1, 1, oe, os);
    chk("arst_tx_empty", 32'(oe), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
